// File: rtl/pattern_detect_pkg.sv
// rtl/pattern_detect_pkg.sv - shared types and helpers for the pattern detector
// Purpose: FSM state encoding, state width and fill-counter width helper.
// Ports: none (package).
package pattern_detect_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    EMPTY = 2'b00,
    FILL  = 2'b01,
    ARMED = 2'b10
  } state_t;

  // Fill counter must hold values 0..PAT_W inclusive.
  function automatic int fill_width(input int pat_w);
    return $clog2(pat_w + 1);
  endfunction

endpackage

// File: rtl/pd_sat_counter.sv
// rtl/pd_sat_counter.sv - saturating up-counter with clear priority
// Purpose: counts inc pulses, sticks at all-ones, clr wins over inc.
// Ports: clk, rst (async active-high), inc, clr, count[CNT_W-1:0].
module pd_sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != CNT_MAX)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pattern_detector_param.sv
// rtl/pattern_detector_param.sv - parametrised serial bit-pattern detector
// Purpose: matches a PAT_W-bit PATTERN (MSB first) on a valid-gated serial
//   stream, overlapping or non-overlapping, with a saturating match counter.
// Ports: clk, rst (async active-high), datain, din_valid, overlap_en,
//   clear_cnt, pattern_detected (registered pulse), match_count[CNT_W-1:0],
//   state[1:0] (debug FSM view), care_mask[PAT_W-1:0] (PATDET_MASK_EN only).
// Optional feature macro: PATDET_MASK_EN.
module pattern_detector_param
  import pattern_detect_pkg::*;
#(
  parameter int               PAT_W   = 3,
  parameter logic [PAT_W-1:0] PATTERN = 3'b101,
  parameter int               CNT_W   = 8
) (
`ifdef PATDET_MASK_EN
  input  logic [PAT_W-1:0]   care_mask,
`endif
  input  logic               clk,
  input  logic               rst,
  input  logic               datain,
  input  logic               din_valid,
  input  logic               overlap_en,
  input  logic               clear_cnt,
  output logic               pattern_detected,
  output logic [CNT_W-1:0]   match_count,
  output logic [STATE_W-1:0] state
);

  localparam int             FW   = fill_width(PAT_W);
  localparam logic [FW-1:0]  FULL = FW'(PAT_W);

  logic [PAT_W-1:0] sr;
  logic [FW-1:0]    fill;
  state_t           st;

  logic [PAT_W-1:0] sr_next;
  logic [FW-1:0]    fill_next;
  logic [PAT_W-1:0] mask;
  logic             match;

`ifdef PATDET_MASK_EN
  assign mask = care_mask;
`else
  assign mask = '1;
`endif

  // Match is judged on the post-shift contents, i.e. including this edge's bit.
  always_comb begin
    sr_next   = (sr << 1) | {{(PAT_W-1){1'b0}}, datain};
    fill_next = (fill == FULL) ? fill : fill + FW'(1);
    match     = din_valid && (fill_next == FULL) &&
                (((sr_next ^ PATTERN) & mask) == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr               <= '0;
      fill             <= '0;
      st               <= EMPTY;
      pattern_detected <= 1'b0;
    end else begin
      pattern_detected <= match;
      if (din_valid) begin
        if (match && !overlap_en) begin
          // Non-overlapping: consumed bits cannot contribute to the next match.
          sr   <= '0;
          fill <= '0;
          st   <= EMPTY;
        end else begin
          sr   <= sr_next;
          fill <= fill_next;
          st   <= (fill_next == FULL) ? ARMED : FILL;
        end
      end
    end
  end

  assign state = st;

  pd_sat_counter #(
    .CNT_W (CNT_W)
  ) u_match_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (match),
    .clr   (clear_cnt),
    .count (match_count)
  );

endmodule

// File: tb/tb_pattern_detector_param.sv
// tb/tb_pattern_detector_param.sv - directed self-checking bench for pattern_detector_param
module tb_pattern_detector_param;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       datain = 1'b0;
  logic       din_valid = 1'b0;
  logic       overlap_en = 1'b1;
  logic       clear_cnt = 1'b0;
  logic [2:0] care_mask = 3'b111;

  logic       pd;
  logic [7:0] cnt;
  logic [1:0] st;
  logic       pd_c2;
  logic [1:0] cnt_c2;
  logic [1:0] st_c2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pattern_detector_param dut (
`ifdef PATDET_MASK_EN
    .care_mask        (care_mask),
`endif
    .clk              (clk),
    .rst              (rst),
    .datain           (datain),
    .din_valid        (din_valid),
    .overlap_en       (overlap_en),
    .clear_cnt        (clear_cnt),
    .pattern_detected (pd),
    .match_count      (cnt),
    .state            (st)
  );

  pattern_detector_param #(.CNT_W(2)) dut_c2 (
`ifdef PATDET_MASK_EN
    .care_mask        (care_mask),
`endif
    .clk              (clk),
    .rst              (rst),
    .datain           (datain),
    .din_valid        (din_valid),
    .overlap_en       (overlap_en),
    .clear_cnt        (clear_cnt),
    .pattern_detected (pd_c2),
    .match_count      (cnt_c2),
    .state            (st_c2)
  );

  task automatic step(input logic b, input logic v, input logic cc);
    @(negedge clk);
    datain    = b;
    din_valid = v;
    clear_cnt = cc;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    din_valid = 1'b0;
    clear_cnt = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    checks++;
    if (pd !== 1'b0) begin errors++; $display("FAIL reset_pd: got %0b expected 0", pd); end
    checks++;
    if (cnt !== 8'd0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", cnt); end
    checks++;
    if (st !== 2'b00) begin errors++; $display("FAIL reset_state: got %0b expected 00", st); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_overlap();
    logic [5:0] bits   = 6'b101010;
    logic [5:0] exp_pd = 6'b001010;
    logic [1:0] exp_st [6] = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10};
    apply_reset();
    overlap_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step(bits[5-i], 1'b1, 1'b0);
      checks++;
      if (pd !== exp_pd[5-i]) begin errors++; $display("FAIL overlap_pd[%0d]: got %0b expected %0b", i, pd, exp_pd[5-i]); end
      checks++;
      if (st !== exp_st[i]) begin errors++; $display("FAIL overlap_state[%0d]: got %0b expected %0b", i, st, exp_st[i]); end
    end
    checks++;
    if (cnt !== 8'd2) begin errors++; $display("FAIL overlap_cnt: got %0d expected 2", cnt); end
  endtask

  task automatic test_non_overlap();
    logic [5:0] bits   = 6'b101010;
    logic [5:0] exp_pd = 6'b001000;
    logic [1:0] exp_st [6] = '{2'b01, 2'b01, 2'b00, 2'b01, 2'b01, 2'b10};
    apply_reset();
    overlap_en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step(bits[5-i], 1'b1, 1'b0);
      checks++;
      if (pd !== exp_pd[5-i]) begin errors++; $display("FAIL nonovl_pd[%0d]: got %0b expected %0b", i, pd, exp_pd[5-i]); end
      checks++;
      if (st !== exp_st[i]) begin errors++; $display("FAIL nonovl_state[%0d]: got %0b expected %0b", i, st, exp_st[i]); end
    end
    checks++;
    if (cnt !== 8'd1) begin errors++; $display("FAIL nonovl_cnt: got %0d expected 1", cnt); end
    overlap_en = 1'b1;
  endtask

  task automatic test_valid_gaps();
    // Held cycles drive datain=1 so a leak of invalid data would match early.
    logic       b  [9] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic       v  [9] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic       ep [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [1:0] es [9] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10};
    apply_reset();
    overlap_en = 1'b1;
    for (int i = 0; i < 9; i++) begin
      step(b[i], v[i], 1'b0);
      checks++;
      if (pd !== ep[i]) begin errors++; $display("FAIL gaps_pd[%0d]: got %0b expected %0b", i, pd, ep[i]); end
      checks++;
      if (st !== es[i]) begin errors++; $display("FAIL gaps_state[%0d]: got %0b expected %0b", i, st, es[i]); end
    end
    checks++;
    if (cnt !== 8'd1) begin errors++; $display("FAIL gaps_cnt: got %0d expected 1", cnt); end
  endtask

  task automatic test_saturate_clear();
    logic [10:0] bits = 11'b10101010101;
    logic [1:0]  ec [11] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3};
    apply_reset();
    overlap_en = 1'b1;
    for (int i = 0; i < 11; i++) begin
      step(bits[10-i], 1'b1, 1'b0);
      checks++;
      if (cnt_c2 !== ec[i]) begin errors++; $display("FAIL sat_cnt2[%0d]: got %0d expected %0d", i, cnt_c2, ec[i]); end
    end
    checks++;
    if (cnt !== 8'd5) begin errors++; $display("FAIL sat_cnt8: got %0d expected 5", cnt); end
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    checks++;
    if (pd_c2 !== 1'b1) begin errors++; $display("FAIL clr_pulse: got %0b expected 1", pd_c2); end
    checks++;
    if (cnt_c2 !== 2'd0) begin errors++; $display("FAIL clr_cnt2: got %0d expected 0", cnt_c2); end
    checks++;
    if (cnt !== 8'd0) begin errors++; $display("FAIL clr_cnt8: got %0d expected 0", cnt); end
    clear_cnt = 1'b0;
  endtask

  task automatic test_async_reset();
    logic [4:0] bits = 5'b10110;
    apply_reset();
    overlap_en = 1'b1;
    for (int i = 0; i < 5; i++) step(bits[4-i], 1'b1, 1'b0);
    checks++;
    if (cnt !== 8'd1 || st !== 2'b10) begin errors++; $display("FAIL pre_rst: got cnt=%0d st=%0b expected cnt=1 st=10", cnt, st); end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (st !== 2'b00) begin errors++; $display("FAIL arst_state: got %0b expected 00", st); end
    checks++;
    if (cnt !== 8'd0) begin errors++; $display("FAIL arst_cnt: got %0d expected 0", cnt); end
    checks++;
    if (pd !== 1'b0) begin errors++; $display("FAIL arst_pd: got %0b expected 0", pd); end
    din_valid = 1'b1;
    datain    = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (st !== 2'b00 || pd !== 1'b0) begin errors++; $display("FAIL arst_hold: got st=%0b pd=%0b expected st=00 pd=0", st, pd); end
    @(negedge clk);
    rst = 1'b0;
    din_valid = 1'b0;
    step(1'b1, 1'b1, 1'b0);
    checks++;
    if (pd !== 1'b0) begin errors++; $display("FAIL post_rst_single: got %0b expected 0", pd); end
    checks++;
    if (st !== 2'b01) begin errors++; $display("FAIL post_rst_state: got %0b expected 01", st); end
    apply_reset();
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    checks++;
    if (pd !== 1'b1) begin errors++; $display("FAIL post_rst_fresh: got %0b expected 1", pd); end
  endtask

`ifdef PATDET_MASK_EN
  task automatic test_mask();
    apply_reset();
    care_mask = 3'b101;
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    checks++;
    if (pd !== 1'b1) begin errors++; $display("FAIL mask_101: got %0b expected 1", pd); end
    apply_reset();
    care_mask = 3'b111;
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    checks++;
    if (pd !== 1'b0) begin errors++; $display("FAIL mask_111: got %0b expected 0", pd); end
  endtask
`endif

  initial begin
    test_reset();
    test_overlap();
    test_non_overlap();
    test_valid_gaps();
    test_saturate_clear();
    test_async_reset();
`ifdef PATDET_MASK_EN
    test_mask();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
